// File: rtl/legv8_instr_encoder_pkg.sv
// Shared definitions for the LEGv8 instruction encoder.
//   - op select codes accepted on in_op
//   - fixed opcode fields for each instruction format (same values the
//     control decoder matches against)
//   - encode(): combinational assembly of one machine word plus a legality flag
package legv8_instr_encoder_pkg;

   typedef enum logic [3:0] {
      ENC_AND  = 4'd0,
      ENC_ORR  = 4'd1,
      ENC_ADD  = 4'd2,
      ENC_SUB  = 4'd3,
      ENC_ADDI = 4'd4,
      ENC_SUBI = 4'd5,
      ENC_LDUR = 4'd6,
      ENC_STUR = 4'd7,
      ENC_B    = 4'd8,
      ENC_CBZ  = 4'd9,
      ENC_MOVZ = 4'd10
   } enc_op_e;

   // R-format, 11-bit opcodes
   localparam logic [10:0] OPC_AND  = 11'b10001010000;
   localparam logic [10:0] OPC_ORR  = 11'b10101010000;
   localparam logic [10:0] OPC_ADD  = 11'b10001011000;
   localparam logic [10:0] OPC_SUB  = 11'b11001011000;
   // I-format, 10-bit opcodes
   localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
   localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
   // D-format, 11-bit opcodes
   localparam logic [10:0] OPC_LDUR = 11'b11111000010;
   localparam logic [10:0] OPC_STUR = 11'b11111000000;
   // B / CB / IW formats
   localparam logic [5:0]  OPC_B    = 6'b000101;
   localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
   localparam logic [8:0]  OPC_MOVZ = 9'b110100101;

   typedef struct packed {
      logic        legal;
      logic [31:0] word;
   } enc_result_t;

   function automatic enc_result_t encode(
      input logic [3:0]  op,
      input logic [4:0]  rd,
      input logic [4:0]  rn,
      input logic [4:0]  rm,
      input logic [5:0]  shamt,
      input logic [1:0]  hw,
      input logic [31:0] imm
   );
      enc_result_t r;
      r.legal = 1'b1;
      r.word  = '0;
      case (op)
         ENC_AND:  r.word = {OPC_AND, rm, shamt, rn, rd};
         ENC_ORR:  r.word = {OPC_ORR, rm, shamt, rn, rd};
         ENC_ADD:  r.word = {OPC_ADD, rm, shamt, rn, rd};
         ENC_SUB:  r.word = {OPC_SUB, rm, shamt, rn, rd};
         ENC_ADDI, ENC_SUBI: begin
            // unsigned 12-bit immediate
            r.legal = (imm[31:12] == 20'd0);
            r.word  = {(op == ENC_ADDI) ? OPC_ADDI : OPC_SUBI, imm[11:0], rn, rd};
         end
         ENC_LDUR, ENC_STUR: begin
            // signed 9-bit: every bit above the sign bit must copy it
            r.legal = (imm[31:8] == {24{imm[8]}});
            r.word  = {(op == ENC_LDUR) ? OPC_LDUR : OPC_STUR, imm[8:0], 2'b00, rn, rd};
         end
         ENC_B: begin
            r.legal = (imm[31:25] == {7{imm[25]}});
            r.word  = {OPC_B, imm[25:0]};
         end
         ENC_CBZ: begin
            r.legal = (imm[31:18] == {14{imm[18]}});
            r.word  = {OPC_CBZ, imm[18:0], rd};
         end
         ENC_MOVZ: begin
            r.legal = (imm[31:16] == 16'd0);
            r.word  = {OPC_MOVZ, hw, imm[15:0], rd};
         end
         default: r.legal = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/legv8_instr_encoder_sync_fifo.sv
// Synchronous FIFO holding encoded instruction words.
// Ports:
//   CLK, resetl        clock, async active-low reset (clears pointers and storage)
//   wr_en, wr_data     write request; ignored while full
//   rd_en              pop request; ignored while empty
//   rd_data            word at head (valid while !empty)
//   full, empty        status from pointer compare
module legv8_instr_encoder_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             resetl,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   // one extra MSB per pointer separates the full and empty cases
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_wr;
   logic             do_rd;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
   assign do_wr   = wr_en & ~full;
   assign do_rd   = rd_en & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (do_wr) begin
         mem_d[wr_ptr_q[AW-1:0]] = wr_data;
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/legv8_instr_encoder.sv
// LEGv8 instruction encoder for the test loader.
// Assembles a 32-bit machine word from an op select plus register/immediate
// fields, queues it, and streams it out with an incrementing byte address.
// Ports:
//   CLK, resetl                       clock, async active-low reset
//   in_valid/in_ready                 request handshake (in_ready = !full)
//   in_op,in_rd,in_rn,in_rm,in_shamt,in_hw,in_imm   instruction fields
//   base_load/base_addr               reload the address counter
//   out_valid/out_ready               word handshake toward instruction memory
//   out_addr/out_data                 byte address and word at FIFO head
//   err_pulse/err_count               dropped-request pulse and saturating count
module legv8_instr_encoder
   import legv8_instr_encoder_pkg::*;
#(
   parameter int                DEPTH  = 4,
   parameter int                ADDR_W = 64,
   parameter logic [ADDR_W-1:0] BASE   = '0
) (
   input  logic              CLK,
   input  logic              resetl,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rn,
   input  logic [4:0]        in_rm,
   input  logic [5:0]        in_shamt,
   input  logic [1:0]        in_hw,
   input  logic [31:0]       in_imm,
   input  logic              base_load,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [31:0]       out_data,
   output logic              err_pulse,
   output logic [7:0]        err_count
);

   enc_result_t       enc;
   logic              fifo_full;
   logic              fifo_empty;
   logic              accept;
   logic              push;
   logic              drop;
   logic              pop;

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              err_pulse_q, err_pulse_d;
   logic [7:0]        err_count_q, err_count_d;

   always_comb begin
      enc = encode(in_op, in_rd, in_rn, in_rm, in_shamt, in_hw, in_imm);
   end

   assign in_ready  = ~fifo_full;
   assign out_valid = ~fifo_empty;
   assign accept    = in_valid & in_ready;
   // illegal requests are still consumed so the loader never stalls on them
   assign push      = accept & enc.legal;
   assign drop      = accept & ~enc.legal;
   assign pop       = out_valid & out_ready;

   legv8_instr_encoder_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .CLK     (CLK),
      .resetl  (resetl),
      .wr_en   (push),
      .wr_data (enc.word),
      .rd_en   (out_ready),
      .rd_data (out_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      addr_d      = addr_q;
      err_pulse_d = drop;
      err_count_d = err_count_q;
      if (pop) begin
         addr_d = addr_q + ADDR_W'(4);
      end
      // a reload overrides the increment; the word popped this cycle
      // already went out with the old address
      if (base_load) begin
         addr_d = base_addr;
      end
      if (drop && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         addr_q      <= BASE;
         err_pulse_q <= 1'b0;
         err_count_q <= 8'd0;
      end else begin
         addr_q      <= addr_d;
         err_pulse_q <= err_pulse_d;
         err_count_q <= err_count_d;
      end
   end

   assign out_addr  = addr_q;
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_legv8_instr_encoder.sv
module tb_legv8_instr_encoder;

   localparam int ADDR_W = 64;

   logic              CLK = 1'b0;
   logic              resetl;
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_op;
   logic [4:0]        in_rd, in_rn, in_rm;
   logic [5:0]        in_shamt;
   logic [1:0]        in_hw;
   logic [31:0]       in_imm;
   logic              base_load;
   logic [ADDR_W-1:0] base_addr;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_addr;
   logic [31:0]       out_data;
   logic              err_pulse;
   logic [7:0]        err_count;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0]       exp_q[$];
   logic [ADDR_W-1:0] model_addr = '0;

   legv8_instr_encoder #(.DEPTH(4), .ADDR_W(ADDR_W), .BASE('0)) dut (
      .CLK(CLK), .resetl(resetl),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
      .in_shamt(in_shamt), .in_hw(in_hw), .in_imm(in_imm),
      .base_load(base_load), .base_addr(base_addr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_addr(out_addr), .out_data(out_data),
      .err_pulse(err_pulse), .err_count(err_count)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // caller is at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                       input logic [4:0] rm, input logic [5:0] sh, input logic [1:0] hw,
                       input logic [31:0] imm, input logic legal, input logic [31:0] exp);
      int  n;
      logic got;
      n = 0;
      got = 1'b0;
      in_op = op; in_rd = rd; in_rn = rn; in_rm = rm;
      in_shamt = sh; in_hw = hw; in_imm = imm;
      in_valid = 1'b1;
      while (!got && n < 50) begin
         @(negedge CLK);
         if (in_ready) begin
            got = 1'b1;
            if (legal) exp_q.push_back(exp);
         end
         @(posedge CLK);
         #1;
         n++;
      end
      in_valid = 1'b0;
      if (!got) chk("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         tick();
         n++;
      end
      chk(name, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      resetl = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_out_addr",  out_addr,       64'd0);
      chk("rst_err_pulse", 64'(err_pulse), 64'd0);
      chk("rst_err_count", 64'(err_count), 64'd0);
      exp_q.delete();
      model_addr = '0;
      tick();
      tick();
      resetl = 1'b1;
      tick();
   endtask

   // scoreboard monitor: sample at negedge, away from the active edge
   always @(negedge CLK) begin
      if (resetl) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               chk("mon_data", 64'(out_data), 64'(exp_q[0]));
               chk("mon_addr", out_addr, model_addr);
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  model_addr = model_addr + 64'd4;
               end
            end
         end
         if (base_load) model_addr = base_addr;
      end
   end

   initial begin
      in_valid = 0; in_op = 0; in_rd = 0; in_rn = 0; in_rm = 0;
      in_shamt = 0; in_hw = 0; in_imm = 0;
      base_load = 0; base_addr = '0; out_ready = 0;
      resetl = 1'b0;
      tick();
      do_reset();

      // encodings, streaming
      out_ready = 1'b1;
      send(4'd2, 5'd3, 5'd1, 5'd2, 6'd0, 2'd0, 32'd0, 1'b1, 32'h8B020023);
      chk("add_latency_valid", 64'(out_valid), 64'd1);
      chk("add_latency_data",  64'(out_data),  64'h8B020023);
      send(4'd4, 5'd1, 5'd31, 5'd0, 6'd0, 2'd0, 32'd5,        1'b1, 32'h910017E1);
      send(4'd6, 5'd2, 5'd1,  5'd0, 6'd0, 2'd0, 32'd8,        1'b1, 32'hF8408022);
      send(4'd8, 5'd0, 5'd0,  5'd0, 6'd0, 2'd0, 32'hFFFFFFFF, 1'b1, 32'h17FFFFFF);
      send(4'd9, 5'd5, 5'd0,  5'd0, 6'd0, 2'd0, 32'd2,        1'b1, 32'hB4000045);
      send(4'd10,5'd9, 5'd0,  5'd0, 6'd0, 2'd1, 32'h1234,     1'b1, 32'hD2A24689);
      send(4'd3, 5'd4, 5'd5,  5'd6, 6'd0, 2'd0, 32'd0,        1'b1, 32'hCB0600A4);
      send(4'd1, 5'd1, 5'd2,  5'd3, 6'd4, 2'd0, 32'd0,        1'b1, 32'hAA031041);
      send(4'd0, 5'd31,5'd31, 5'd31,6'd63,2'd0, 32'hDEADBEEF, 1'b1, 32'h8A1FFFFF);
      send(4'd7, 5'd7, 5'd8,  5'd0, 6'd0, 2'd0, 32'hFFFFFF00, 1'b1, 32'hF8100107);
      send(4'd5, 5'd0, 5'd0,  5'd0, 6'd0, 2'd0, 32'd4095,     1'b1, 32'hD13FFC00);
      send(4'd6, 5'd0, 5'd0,  5'd0, 6'd0, 2'd0, 32'd255,      1'b1, 32'hF84FF000);
      send(4'd8, 5'd0, 5'd0,  5'd0, 6'd0, 2'd0, 32'h01FFFFFF, 1'b1, 32'h15FFFFFF);
      send(4'd9, 5'd0, 5'd0,  5'd0, 6'd0, 2'd0, 32'hFFFC0000, 1'b1, 32'hB4800000);
      drain("drain_encodings");
      chk("err_count_after_legal", 64'(err_count), 64'd0);

      // full FIFO backpressure
      do_reset();
      out_ready = 1'b0;
      send(4'd2, 5'd3, 5'd1, 5'd2, 6'd0, 2'd0, 32'd0, 1'b1, 32'h8B020023);
      send(4'd4, 5'd1, 5'd31,5'd0, 6'd0, 2'd0, 32'd5, 1'b1, 32'h910017E1);
      send(4'd6, 5'd2, 5'd1, 5'd0, 6'd0, 2'd0, 32'd8, 1'b1, 32'hF8408022);
      chk("in_ready_before_full", 64'(in_ready), 64'd1);
      send(4'd9, 5'd5, 5'd0, 5'd0, 6'd0, 2'd0, 32'd2, 1'b1, 32'hB4000045);
      chk("in_ready_full", 64'(in_ready), 64'd0);
      chk("stall_head_data", 64'(out_data), 64'h8B020023);
      chk("stall_head_addr", out_addr, 64'd0);
      fork
         send(4'd10, 5'd9, 5'd0, 5'd0, 6'd0, 2'd1, 32'h1234, 1'b1, 32'hD2A24689);
         begin
            tick(); tick(); tick();
            chk("in_ready_full_held", 64'(in_ready), 64'd0);
            out_ready = 1'b1;
         end
      join
      drain("drain_full");
      chk("addr_after_five", out_addr, 64'd20);

      // error handling and saturation
      do_reset();
      out_ready = 1'b1;
      send(4'd12, 5'd0, 5'd0, 5'd0, 6'd0, 2'd0, 32'd0, 1'b0, 32'd0);
      chk("err_pulse_illegal_op", 64'(err_pulse), 64'd1);
      send(4'd4, 5'd1, 5'd1, 5'd0, 6'd0, 2'd0, 32'd4096, 1'b0, 32'd0);
      chk("err_pulse_addi_range", 64'(err_pulse), 64'd1);
      chk("err_count_two", 64'(err_count), 64'd2);
      tick();
      chk("err_pulse_clears", 64'(err_pulse), 64'd0);
      chk("no_write_on_error", 64'(out_valid), 64'd0);
      send(4'd6,  5'd0, 5'd0, 5'd0, 6'd0, 2'd0, 32'd256,      1'b0, 32'd0);
      send(4'd8,  5'd0, 5'd0, 5'd0, 6'd0, 2'd0, 32'h02000000, 1'b0, 32'd0);
      send(4'd10, 5'd0, 5'd0, 5'd0, 6'd0, 2'd0, 32'h00010000, 1'b0, 32'd0);
      send(4'd9,  5'd0, 5'd0, 5'd0, 6'd0, 2'd0, 32'h00040000, 1'b0, 32'd0);
      send(4'd7,  5'd0, 5'd0, 5'd0, 6'd0, 2'd0, 32'hFFFFFEFF, 1'b0, 32'd0);
      chk("err_count_seven", 64'(err_count), 64'd7);
      chk("no_write_range", 64'(out_valid), 64'd0);
      for (int i = 0; i < 248; i++) begin
         send(4'd15, 5'd0, 5'd0, 5'd0, 6'd0, 2'd0, 32'd0, 1'b0, 32'd0);
      end
      chk("err_count_255", 64'(err_count), 64'd255);
      send(4'd11, 5'd0, 5'd0, 5'd0, 6'd0, 2'd0, 32'd0, 1'b0, 32'd0);
      chk("err_count_saturated", 64'(err_count), 64'd255);
      chk("err_pulse_at_saturation", 64'(err_pulse), 64'd1);

      // base reload
      base_addr = 64'h1000;
      base_load = 1'b1;
      tick();
      base_load = 1'b0;
      chk("base_loaded", out_addr, 64'h1000);
      send(4'd2, 5'd3, 5'd1, 5'd2, 6'd0, 2'd0, 32'd0, 1'b1, 32'h8B020023);
      chk("word_at_base_addr", out_addr, 64'h1000);
      drain("drain_base");

      // base_load coincident with a pop
      out_ready = 1'b0;
      send(4'd4, 5'd1, 5'd31, 5'd0, 6'd0, 2'd0, 32'd5, 1'b1, 32'h910017E1);
      send(4'd6, 5'd2, 5'd1,  5'd0, 6'd0, 2'd0, 32'd8, 1'b1, 32'hF8408022);
      chk("pre_load_addr", out_addr, 64'h1004);
      base_addr = 64'h2000;
      base_load = 1'b1;
      out_ready = 1'b1;
      tick();
      base_load = 1'b0;
      chk("load_wins_addr", out_addr, 64'h2000);
      chk("load_wins_data", 64'(out_data), 64'hF8408022);
      drain("drain_load_pop");

      // reset with words queued
      out_ready = 1'b0;
      send(4'd8, 5'd0, 5'd0, 5'd0, 6'd0, 2'd0, 32'hFFFFFFFF, 1'b1, 32'h17FFFFFF);
      send(4'd9, 5'd5, 5'd0, 5'd0, 6'd0, 2'd0, 32'd2,        1'b1, 32'hB4000045);
      send(4'd10,5'd9, 5'd0, 5'd0, 6'd0, 2'd1, 32'h1234,     1'b1, 32'hD2A24689);
      chk("queued_before_reset", 64'(out_valid), 64'd1);
      do_reset();
      send(4'd10,5'd9, 5'd0, 5'd0, 6'd0, 2'd1, 32'h1234, 1'b1, 32'hD2A24689);
      chk("post_reset_addr", out_addr, 64'd0);
      chk("post_reset_data", 64'(out_data), 64'hD2A24689);
      out_ready = 1'b1;
      drain("drain_post_reset");
      tick();
      chk("final_empty", 64'(out_valid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
